// File: rtl/mul_pkg.sv
// Shared types and defaults for the limb-serial multiplier.
// The limb-select index width helper keeps counters sized to the limb count.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LIMB_W_DEF    = 20;
  localparam int NUM_LIMBS_DEF = 4;

  function automatic int limb_idx_w(input int num_limbs);
    return (num_limbs > 1) ? $clog2(num_limbs) : 1;
  endfunction

endpackage

// File: rtl/mul_limb_row.sv
// Combinational LIMB_W x MUL_SIZE row product built from NUM_LIMBS
// LIMB_W x LIMB_W partial products (one DSP each), summed at limb offsets.
module mul_limb_row
  import mul_pkg::*;
#(
  parameter int LIMB_W    = LIMB_W_DEF,
  parameter int NUM_LIMBS = NUM_LIMBS_DEF,
  localparam int MUL_SIZE = LIMB_W * NUM_LIMBS,
  localparam int ROW_W    = LIMB_W + MUL_SIZE
) (
  input  logic [LIMB_W-1:0]   a_limb,
  input  logic [MUL_SIZE-1:0] b,
  output logic [ROW_W-1:0]    row
);

  logic [2*LIMB_W-1:0] part [NUM_LIMBS];

  for (genvar i = 0; i < NUM_LIMBS; i++) begin : g_dsp
    assign part[i] = (2*LIMB_W)'(a_limb) * (2*LIMB_W)'(b[i*LIMB_W +: LIMB_W]);
  end

  // The top partial product shifted by (NUM_LIMBS-1)*LIMB_W exactly fills ROW_W.
  always_comb begin
    row = '0;
    for (int i = 0; i < NUM_LIMBS; i++) begin
      row = row + (ROW_W'(part[i]) << (i * LIMB_W));
    end
  end

endmodule

// File: rtl/mul_limb_serial.sv
// Limb-serial multiplier: one limb of |a| times all of |b| per cycle,
// accumulated into a double-width sum, with sign fix-up and ready/valid handshake.
module mul_limb_serial
  import mul_pkg::*;
#(
  parameter int LIMB_W    = LIMB_W_DEF,
  parameter int NUM_LIMBS = NUM_LIMBS_DEF,
  localparam int MUL_SIZE = LIMB_W * NUM_LIMBS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MUL_SIZE-1:0]   a,
  input  logic [MUL_SIZE-1:0]   b,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MUL_SIZE-1:0] res,
  output logic                  busy
);

  localparam int IDX_W = limb_idx_w(NUM_LIMBS);
  localparam int ROW_W = LIMB_W + MUL_SIZE;
  localparam int ACC_W = 2 * MUL_SIZE;
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_LIMBS - 1);

  state_t state, state_next;

  logic [MUL_SIZE-1:0]                  a_reg, b_reg;
  logic [NUM_LIMBS-1:0][LIMB_W-1:0]     a_limbs;
  logic                                 neg;
  logic [ACC_W-1:0]                     acc, acc_add, acc_sum;
  logic [IDX_W-1:0]                     cnt;
  logic [ROW_W-1:0]                     row;
  logic [MUL_SIZE-1:0]                  a_mag, b_mag;
  logic                                 accept, last_limb;

  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_limb = (cnt == LAST_CNT);

  // -2^(MUL_SIZE-1) negates to itself, which read as unsigned is the correct magnitude.
  assign a_mag = (is_signed && a[MUL_SIZE-1]) ? -a : a;
  assign b_mag = (is_signed && b[MUL_SIZE-1]) ? -b : b;

  assign a_limbs = a_reg;

  mul_limb_row #(
    .LIMB_W    (LIMB_W),
    .NUM_LIMBS (NUM_LIMBS)
  ) u_row (
    .a_limb (a_limbs[cnt]),
    .b      (b_reg),
    .row    (row)
  );

  always_comb begin
    acc_add = '0;
    for (int i = 0; i < NUM_LIMBS; i++) begin
      if (cnt == IDX_W'(i)) acc_add = ACC_W'(row) << (i * LIMB_W);
    end
  end

  assign acc_sum = acc + acc_add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // flush overrides every handshake, including a consume in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MUL;
      MUL:     if (last_limb) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      res   <= '0;
    end else if (flush) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a_mag;
            b_reg <= b_mag;
            neg   <= is_signed & (a[MUL_SIZE-1] ^ b[MUL_SIZE-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        MUL: begin
          if (last_limb) begin
            res <= neg ? -acc_sum : acc_sum;
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= acc_sum;
            cnt <= cnt + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_limb_serial.sv
// Self-checking bench for mul_limb_serial: directed corners plus random operands
// compared against a plain-arithmetic product model.
module tb_mul_limb_serial;

  localparam int LW  = 20;
  localparam int NL  = 4;
  localparam int MS  = LW * NL;
  localparam int RW  = 2 * MS;
  localparam int LW2 = 16;
  localparam int NL2 = 3;
  localparam int MS2 = LW2 * NL2;
  localparam int RW2 = 2 * MS2;

  logic          clk, rst_n, flush, in_valid, in_ready, is_signed;
  logic          out_valid, out_ready, busy;
  logic [MS-1:0] a, b;
  logic [RW-1:0] res;

  logic           in_valid_s, in_ready_s, out_valid_s, busy_s, is_signed_s;
  logic [MS2-1:0] a_s, b_s;
  logic [RW2-1:0] res_s;

  int checks = 0;
  int errors = 0;

  mul_limb_serial #(.LIMB_W(LW), .NUM_LIMBS(NL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  mul_limb_serial #(.LIMB_W(LW2), .NUM_LIMBS(NL2)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .a(a_s), .b(b_s), .is_signed(is_signed_s), .out_valid(out_valid_s), .out_ready(1'b1),
    .res(res_s), .busy(busy_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [RW-1:0] ref_prod(input logic [MS-1:0] x, input logic [MS-1:0] y,
                                            input logic s);
    logic signed [RW-1:0] sx, sy;
    logic [RW-1:0] ux, uy;
    sx = {{MS{x[MS-1]}}, x};
    sy = {{MS{y[MS-1]}}, y};
    ux = {{MS{1'b0}}, x};
    uy = {{MS{1'b0}}, y};
    return s ? RW'(sx * sy) : ux * uy;
  endfunction

  function automatic logic [RW2-1:0] ref_prod_s(input logic [MS2-1:0] x, input logic [MS2-1:0] y);
    logic signed [RW2-1:0] sx, sy;
    sx = {{MS2{x[MS2-1]}}, x};
    sy = {{MS2{y[MS2-1]}}, y};
    return RW2'(sx * sy);
  endfunction

  function automatic logic [MS-1:0] rand_op();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return {MS{1'b1}};
      1:       return '0;
      2:       return {1'b1, {(MS-1){1'b0}}};
      default: return r[MS-1:0];
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operand pair, scrambles the inputs after accept,
  // then counts edges until out_valid (bounded).
  task automatic run_op(input logic [MS-1:0] x, input logic [MS-1:0] y, input logic s,
                        output logic [RW-1:0] r, output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin step(); k++; end
    a = x; b = y; is_signed = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = ~x; b = ~y; is_signed = ~s;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    r = res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; is_signed = 1'b0;
    in_valid_s = 1'b0; a_s = '0; b_s = '0; is_signed_s = 1'b1;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    checks++; if (res !== '0) begin errors++; $display("[TB] FAIL reset_res got %h exp 0", res); end
    #9 rst_n = 1'b1;
    step();
  endtask

  task automatic test_unsigned_basic();
    logic [RW-1:0] r;
    int lat;
    out_ready = 1'b1;
    run_op(80'd3, 80'd5, 1'b0, r, lat);
    checks++; if (lat !== NL) begin errors++; $display("[TB] FAIL basic_latency got %0d exp %0d", lat, NL); end
    checks++; if (r !== 160'd15) begin errors++; $display("[TB] FAIL basic_res got %h exp %h", r, 160'd15); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_pulse got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_idle got %b exp 1", in_ready); end
  endtask

  task automatic test_unsigned_max();
    logic [RW-1:0] r, exp_v;
    int lat;
    exp_v = 160'hFFFFFFFFFFFFFFFFFFFE_00000000000000000001;
    run_op({MS{1'b1}}, {MS{1'b1}}, 1'b0, r, lat);
    checks++; if (r !== exp_v) begin errors++; $display("[TB] FAIL umax_res got %h exp %h", r, exp_v); end
  endtask

  task automatic test_signed();
    logic [RW-1:0] r, exp_v;
    logic [MS-1:0] mn;
    int lat;
    mn = {1'b1, {(MS-1){1'b0}}};
    run_op(-80'd1, 80'd2, 1'b1, r, lat);
    exp_v = -160'd2;
    checks++; if (r !== exp_v) begin errors++; $display("[TB] FAIL signed_m1x2 got %h exp %h", r, exp_v); end
    run_op(mn, mn, 1'b1, r, lat);
    exp_v = 160'd1 << 158;
    checks++; if (r !== exp_v) begin errors++; $display("[TB] FAIL signed_minxmin got %h exp %h", r, exp_v); end
    run_op(-80'd7, 80'd6, 1'b1, r, lat);
    exp_v = -160'd42;
    checks++; if (r !== exp_v) begin errors++; $display("[TB] FAIL signed_m7x6 got %h exp %h", r, exp_v); end
  endtask

  task automatic test_random();
    logic [RW-1:0] r, exp_v;
    logic [MS-1:0] x, y;
    logic s;
    int lat;
    for (int i = 0; i < 24; i++) begin
      x = rand_op(); y = rand_op(); s = 1'($urandom_range(0, 1));
      exp_v = ref_prod(x, y, s);
      run_op(x, y, s, r, lat);
      checks++; if (r !== exp_v) begin errors++; $display("[TB] FAIL random_res[%0d] a=%h b=%h s=%b got %h exp %h", i, x, y, s, r, exp_v); end
      checks++; if (lat !== NL) begin errors++; $display("[TB] FAIL random_latency[%0d] got %0d exp %0d", i, lat, NL); end
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] r, exp_v;
    logic [MS-1:0] x, y;
    int lat;
    x = rand_op(); y = rand_op();
    exp_v = ref_prod(x, y, 1'b1);
    step();
    out_ready = 1'b0;
    run_op(x, y, 1'b1, r, lat);
    checks++; if (r !== exp_v) begin errors++; $display("[TB] FAIL bp_res got %h exp %h", r, exp_v); end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (res !== exp_v) begin errors++; $display("[TB] FAIL bp_hold_res[%0d] got %h exp %h", i, res, exp_v); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy[%0d] got %b exp 1", i, busy); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_busy got %b exp 0", busy); end
  endtask

  task automatic test_flush_mul();
    logic [RW-1:0] r;
    int lat, seen;
    out_ready = 1'b1;
    a = rand_op(); b = rand_op(); is_signed = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready got %b exp 0", in_ready); end
    step();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got %b exp 0", busy); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL flush_no_valid got %0d exp 0", seen); end
    run_op(80'd10, 80'd10, 1'b0, r, lat);
    checks++; if (r !== 160'd100) begin errors++; $display("[TB] FAIL flush_after_res got %h exp %h", r, 160'd100); end
    checks++; if (lat !== NL) begin errors++; $display("[TB] FAIL flush_after_latency got %0d exp %0d", lat, NL); end
  endtask

  task automatic test_flush_done();
    logic [RW-1:0] r;
    int lat, seen;
    step();
    out_ready = 1'b0;
    run_op(rand_op(), rand_op(), 1'b0, r, lat);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; a = 80'd5; b = 80'd5;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fdone_in_ready got %b exp 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fdone_valid got %b exp 0", out_valid); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy || out_valid) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL fdone_no_accept got %0d exp 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] r, exp_v;
    logic [MS-1:0] x, y;
    int lat;
    out_ready = 1'b1;
    a = rand_op(); b = rand_op(); is_signed = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready got %b exp 1", in_ready); end
    checks++; if (res !== '0) begin errors++; $display("[TB] FAIL rstmid_res got %h exp 0", res); end
    #3 rst_n = 1'b1;
    step();
    x = rand_op(); y = rand_op();
    exp_v = ref_prod(x, y, 1'b1);
    run_op(x, y, 1'b1, r, lat);
    checks++; if (r !== exp_v) begin errors++; $display("[TB] FAIL rstmid_after got %h exp %h", r, exp_v); end
  endtask

  task automatic test_signed_small();
    logic [MS2-1:0] x, y;
    logic [RW2-1:0] exp_v;
    int lat;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin x = -48'd1; y = 48'd2; end
        1: begin x = {1'b1, {(MS2-1){1'b0}}}; y = {1'b1, {(MS2-1){1'b0}}}; end
        2: begin x = -48'd7; y = 48'd6; end
        default: begin x = {$urandom, $urandom} & {MS2{1'b1}}; y = {$urandom, $urandom} & {MS2{1'b1}}; end
      endcase
      exp_v = ref_prod_s(x, y);
      checks++; if (in_ready_s !== 1'b1) begin errors++; $display("[TB] FAIL small_ready[%0d] got %b exp 1", i, in_ready_s); end
      a_s = x; b_s = y; is_signed_s = 1'b1; in_valid_s = 1'b1;
      step();
      in_valid_s = 1'b0; a_s = ~x; b_s = ~y;
      lat = 0;
      while (!out_valid_s && lat < 20) begin step(); lat++; end
      checks++; if (res_s !== exp_v) begin errors++; $display("[TB] FAIL small_res[%0d] got %h exp %h", i, res_s, exp_v); end
      checks++; if (lat !== NL2) begin errors++; $display("[TB] FAIL small_latency[%0d] got %0d exp %0d", i, lat, NL2); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_v;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    while (got < 8 && cyc < 200) begin
      if (out_valid) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (res !== exp_v) begin errors++; $display("[TB] FAIL b2b_res[%0d] got %h exp %h", got, res, exp_v); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_ready[%0d] got %b exp 0", got, in_ready); end
        got++;
      end
      if (in_ready && sent < 8) begin
        a = rand_op(); b = rand_op(); is_signed = 1'($urandom_range(0, 1)); in_valid = 1'b1;
        exp_q.push_back(ref_prod(a, b, is_signed));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got !== 8) begin errors++; $display("[TB] FAIL b2b_count got %0d exp 8", got); end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_unsigned_max();
    test_signed();
    test_random();
    test_backpressure();
    test_flush_mul();
    test_flush_done();
    test_reset_mid();
    test_signed_small();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
